fmps_link_stream_tx: RTL

- Transmit-side counterpart of the FMPS link readout path: accepts an indexed (index, data, valid) FMPS value stream in the sysClk domain and, on each FA strobe, emits one AXI-Stream packet carrying every value written since the previous strobe.
- Feeds the outgoing FMPS link; the Aurora-side clock crossing is a separate FIFO downstream.
- Double-buffered, so input writes for frame N+1 proceed while frame N is transmitted.

---
 rtl/fmps_link_stream_tx_pkg.sv | 22 ++
 rtl/fmps_link_stream_tx_lowest_set.sv | 19 +
 rtl/fmps_link_stream_tx.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fmps_link_stream_tx_pkg.sv
// Shared constants, header layout and FSM encoding for the FMPS link transmitter.
package fmps_link_stream_tx_pkg;

  localparam int FMPS_INDEX_WIDTH = 5;
  localparam logic [7:0] FMPS_MARKER = 8'hA5;

  localparam int HDR_MARKER_LSB = 24;
  localparam int HDR_COUNT_LSB  = 16;
  localparam int HDR_FRAME_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    IDX  = 2'd2,
    DAT  = 2'd3
  } txState_t;

  function automatic logic [15:0] satInc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/fmps_link_stream_tx_lowest_set.sv
// Priority encoder: index of the lowest set bit of a bitmap, plus an any-set flag.
module fmps_lowest_set #(
  parameter int WIDTH = 32,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] bitmap,
  output logic [IDX_W-1:0] lowest,
  output logic             any
);

  always_comb begin
    lowest = '0;
    any    = |bitmap;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (bitmap[i]) lowest = IDX_W'(i);
    end
  end

endmodule

// File: rtl/fmps_link_stream_tx.sv
// Double-buffered FMPS value table; each FA strobe sends the finished bank as one
// AXI-Stream packet (header, then index/data pairs in ascending index order).
//
// state | meaning
// IDLE  | no packet; strobes swap banks and start a packet (or drop the frame)
// HDR   | header word presented
// IDX   | index word presented, RAM read for that index in flight
// DAT   | data word presented from the RAM read register
module fmps_link_stream_tx
  import fmps_link_stream_tx_pkg::*;
#(
  parameter int         INDEX_WIDTH = FMPS_INDEX_WIDTH,
  parameter logic [7:0] MARKER      = FMPS_MARKER
) (
  input  logic                   sysClk,
  input  logic                   sysReset_n,
  input  logic [INDEX_WIDTH-1:0] fmpsIndex,
  input  logic [31:0]            fmpsData,
  input  logic                   fmpsValid,
  input  logic                   FAstrobe,
  input  logic                   inhibit,
  output logic                   linkTVALID,
  input  logic                   linkTREADY,
  output logic                   linkTLAST,
  output logic [31:0]            linkTDATA,
  output logic                   busy,
  output logic [15:0]            frameCount,
  output logic [15:0]            overrunCount,
  output logic [15:0]            droppedCount
);

  localparam int DEPTH = 1 << INDEX_WIDTH;

  logic [1:0]             rstPipe;
  logic                   rstSync_n;
  txState_t               state;
  logic                   bankSel;
  logic [DEPTH-1:0]       present     [2];
  logic [DEPTH-1:0]       presentNext [2];
  logic [DEPTH-1:0]       snap;
  logic [DEPTH-1:0]       snapNext;
  logic [DEPTH-1:0]       oldBits;
  logic [31:0]            mem [2*DEPTH];
  logic [31:0]            ramQ;
  logic [31:0]            txWord;
  logic [31:0]            hdrWord;
  logic                   txValid;
  logic                   txLast;
  logic [INDEX_WIDTH-1:0] lowIdx;
  logic [INDEX_WIDTH-1:0] nextIdx;
  logic                   lowAny;
  logic                   nextAny;
  logic [INDEX_WIDTH:0]   entryCount;
  logic                   strobeIdle;
  logic                   wrBank;
  logic                   accept;

  function automatic logic [INDEX_WIDTH:0] popcount(input logic [DEPTH-1:0] bitmap);
    logic [INDEX_WIDTH:0] n;
    n = '0;
    for (int i = 0; i < DEPTH; i++) n = n + {{INDEX_WIDTH{1'b0}}, bitmap[i]};
    return n;
  endfunction

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) rstPipe <= 2'b00;
    else             rstPipe <= {rstPipe[0], 1'b1};
  end
  assign rstSync_n = rstPipe[1];

  fmps_lowest_set #(.WIDTH(DEPTH), .IDX_W(INDEX_WIDTH)) uLowest (
    .bitmap(snap), .lowest(lowIdx), .any(lowAny)
  );

  assign snapNext = snap & ~(DEPTH'(1) << lowIdx);

  fmps_lowest_set #(.WIDTH(DEPTH), .IDX_W(INDEX_WIDTH)) uNext (
    .bitmap(snapNext), .lowest(nextIdx), .any(nextAny)
  );

  assign strobeIdle = FAstrobe && (state == IDLE);
  assign wrBank     = strobeIdle ? ~bankSel : bankSel;
  assign accept     = txValid && linkTREADY;
  assign oldBits    = present[bankSel];
  assign entryCount = popcount(oldBits);

  always_comb begin
    hdrWord = '0;
    hdrWord[HDR_MARKER_LSB +: 8] = MARKER;
    hdrWord[HDR_COUNT_LSB  +: 8] = 8'(entryCount);
    hdrWord[HDR_FRAME_LSB  +: 16] = frameCount;
  end

  // A write in the strobe cycle already belongs to the freshly cleared bank.
  always_comb begin
    presentNext[0] = present[0];
    presentNext[1] = present[1];
    if (strobeIdle) presentNext[~bankSel] = '0;
    if (fmpsValid)  presentNext[wrBank][fmpsIndex] = 1'b1;
  end

  always_ff @(posedge sysClk) begin
    if (fmpsValid) mem[{wrBank, fmpsIndex}] <= fmpsData;
    if (state == IDX) ramQ <= mem[{~bankSel, lowIdx}];
  end

  always_ff @(posedge sysClk or negedge rstSync_n) begin
    if (!rstSync_n) begin
      state        <= IDLE;
      bankSel      <= 1'b0;
      present      <= '{default: '0};
      snap         <= '0;
      txWord       <= '0;
      txValid      <= 1'b0;
      txLast       <= 1'b0;
      frameCount   <= '0;
      overrunCount <= '0;
      droppedCount <= '0;
    end else begin
      present <= presentNext;
      if (FAstrobe && state != IDLE) overrunCount <= satInc16(overrunCount);
      case (state)
        IDLE: begin
          if (FAstrobe) begin
            bankSel <= ~bankSel;
            if (inhibit) begin
              droppedCount <= satInc16(droppedCount);
            end else begin
              snap    <= oldBits;
              state   <= HDR;
              txValid <= 1'b1;
              txWord  <= hdrWord;
              txLast  <= (oldBits == '0);
            end
          end
        end
        HDR: begin
          if (accept) begin
            frameCount <= frameCount + 16'd1;
            if (lowAny) begin
              state  <= IDX;
              txWord <= 32'(lowIdx);
              txLast <= 1'b0;
            end else begin
              state   <= IDLE;
              txValid <= 1'b0;
              txLast  <= 1'b0;
            end
          end
        end
        IDX: begin
          if (accept) begin
            state  <= DAT;
            txLast <= !nextAny;
          end
        end
        DAT: begin
          if (accept) begin
            snap <= snapNext;
            if (nextAny) begin
              state  <= IDX;
              txWord <= 32'(nextIdx);
              txLast <= 1'b0;
            end else begin
              state   <= IDLE;
              txValid <= 1'b0;
              txLast  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data words come straight from the RAM read register, which holds while stalled.
  assign linkTDATA  = (state == DAT) ? ramQ : txWord;
  assign linkTVALID = txValid;
  assign linkTLAST  = txLast;
  assign busy       = (state != IDLE);

endmodule
